// File: rtl/cgra_cfg_pkg.sv
// Shared state encoding and framing constants for the CGRA configuration sequencer.
package cgra_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      ID,
      PAYLOAD,
      GAP
   } cfg_state_e;

   localparam int SYNC_LEN = 1;
   localparam int ID_W     = 8;
   localparam int BYTE_W   = 8;

endpackage

// File: rtl/cgra_cfg_sequencer_piso.sv
// Parallel-load, MSB-first shift register; load has priority over shift.
module cfg_piso #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         dout
);

   logic [W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load)
         sr_d = din;
      else if (shift)
         sr_d = {sr_q[W-2:0], 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= sr_d;
   end

   assign dout = sr_q[W-1];

endmodule

// File: rtl/cgra_cfg_sequencer.sv
// Walks all tiles, framing sync/ID/payload onto the shared serial config line.
// Optional CGRA_CFG_PARITY_EN appends an even-parity bit after every payload byte.
module cgra_cfg_sequencer
   import cgra_cfg_pkg::*;
#(
   parameter int NUM_TILES      = 9,
   parameter int WORDS_PER_TILE = 16,
   parameter int GAP_CYCLES     = 4,
   parameter int ADDR_W         = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              cfg_rd_en,
   output logic [ADDR_W-1:0] cfg_addr,
   input  logic [7:0]        cfg_rdata,
   output logic              ser_data,
   output logic              ser_valid,
   output logic              busy,
   output logic              done,
   output logic [7:0]        tile_idx
);

   localparam int WW = (WORDS_PER_TILE > 1) ? $clog2(WORDS_PER_TILE) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [WW-1:0]     LAST_WORD = WW'(WORDS_PER_TILE - 1);
   localparam logic [GW-1:0]     LAST_GAP  = GW'(GAP_CYCLES - 1);
   localparam logic [7:0]        LAST_TILE = 8'(NUM_TILES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TILES * WORDS_PER_TILE - 1);

   cfg_state_e        state_q, state_d;
   logic [2:0]        bit_q, bit_d;
   logic [WW-1:0]     word_q, word_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [7:0]        tile_q, tile_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BYTE_W-1:0] rbuf_q, rbuf_d;
   logic              rd_en_q, rd_en_d;
   logic              rd_pend_q, rd_pend_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              valid_q, valid_d;
   logic              ld, sh, byte_end, byte_start;
   logic [BYTE_W-1:0] ld_val;
   logic              piso_out;
`ifdef CGRA_CFG_PARITY_EN
   logic              par_q, par_d;
   logic              acc_q, acc_d;
`endif

   cfg_piso #(.W(BYTE_W)) u_piso (
      .clk  (clk),
      .rst_n(rst),
      .load (ld),
      .shift(sh),
      .din  (ld_val),
      .dout (piso_out)
   );

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      word_d    = word_q;
      gap_d     = gap_q;
      tile_d    = tile_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      addr_d    = addr_q;
      rd_pend_d = rd_en_q;
      rbuf_d    = rbuf_q;
      ld        = 1'b0;
      sh        = 1'b0;
      ld_val    = '0;
      byte_end  = 1'b0;
`ifdef CGRA_CFG_PARITY_EN
      par_d     = par_q;
      acc_d     = acc_q;
`endif
      // Read data lands one cycle after the strobe; address advances past each read.
      if (rd_pend_q) rbuf_d = cfg_rdata;
      if (rd_en_q && addr_q != LAST_ADDR) addr_d = addr_q + ADDR_W'(1);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SYNC;
               busy_d  = 1'b1;
               tile_d  = '0;
               bit_d   = '0;
               word_d  = '0;
               addr_d  = '0;
            end
         end
         SYNC: begin
            if (bit_q == 3'(SYNC_LEN - 1)) begin
               state_d = ID;
               bit_d   = '0;
               ld      = 1'b1;
               ld_val  = tile_q;
            end else begin
               bit_d = bit_q + 3'd1;
            end
         end
         ID: begin
            sh    = 1'b1;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'(ID_W - 1)) begin
               state_d = PAYLOAD;
               word_d  = '0;
               ld      = 1'b1;
               ld_val  = rbuf_q;
`ifdef CGRA_CFG_PARITY_EN
               acc_d   = 1'b0;
`endif
            end
         end
         PAYLOAD: begin
`ifdef CGRA_CFG_PARITY_EN
            if (par_q) begin
               par_d    = 1'b0;
               byte_end = 1'b1;
            end else begin
               sh    = 1'b1;
               bit_d = bit_q + 3'd1;
               acc_d = acc_q ^ piso_out;
               if (bit_q == 3'd7) begin
                  par_d  = 1'b1;
                  acc_d  = 1'b0;
                  ld     = 1'b1;
                  ld_val = {acc_q ^ piso_out, {(BYTE_W-1){1'b0}}};
               end
            end
`else
            sh    = 1'b1;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) byte_end = 1'b1;
`endif
            if (byte_end) begin
               ld = 1'b1;
               if (word_q == LAST_WORD) begin
                  state_d = GAP;
                  gap_d   = '0;
                  ld_val  = '0;
               end else begin
                  word_d = word_q + WW'(1);
                  ld_val = rbuf_q;
               end
            end
         end
         GAP: begin
            if (gap_q == LAST_GAP) begin
               gap_d = '0;
               if (tile_q == LAST_TILE) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  tile_d  = '0;
                  addr_d  = '0;
               end else begin
                  state_d = SYNC;
                  tile_d  = tile_q + 8'd1;
                  bit_d   = '0;
               end
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort && state_q != IDLE) begin
         state_d   = IDLE;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         tile_d    = '0;
         addr_d    = '0;
         bit_d     = '0;
         word_d    = '0;
         gap_d     = '0;
         rd_pend_d = 1'b0;
         rbuf_d    = '0;
         ld        = 1'b1;
         ld_val    = '0;
`ifdef CGRA_CFG_PARITY_EN
         par_d     = 1'b0;
         acc_d     = 1'b0;
`endif
      end

      valid_d = state_d inside {SYNC, ID, PAYLOAD};
`ifdef CGRA_CFG_PARITY_EN
      byte_start = (bit_d == 3'd0) && !par_d;
`else
      byte_start = (bit_d == 3'd0);
`endif
      // Byte 0 is fetched in the first ID cycle, byte k+1 in the first cycle of byte k.
      rd_en_d = (state_d == ID && bit_d == 3'd0) ||
                (state_d == PAYLOAD && byte_start && word_d != LAST_WORD);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         bit_q     <= '0;
         word_q    <= '0;
         gap_q     <= '0;
         tile_q    <= '0;
         addr_q    <= '0;
         rbuf_q    <= '0;
         rd_en_q   <= 1'b0;
         rd_pend_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
`ifdef CGRA_CFG_PARITY_EN
         par_q     <= 1'b0;
         acc_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_q     <= bit_d;
         word_q    <= word_d;
         gap_q     <= gap_d;
         tile_q    <= tile_d;
         addr_q    <= addr_d;
         rbuf_q    <= rbuf_d;
         rd_en_q   <= rd_en_d;
         rd_pend_q <= rd_pend_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
`ifdef CGRA_CFG_PARITY_EN
         par_q     <= par_d;
         acc_q     <= acc_d;
`endif
      end
   end

   assign cfg_rd_en = rd_en_q;
   assign cfg_addr  = addr_q;
   assign ser_data  = piso_out;
   assign ser_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign tile_idx  = tile_q;

endmodule
